crc_dir_arbiter: RTL and testbench
==================================

CRC_DIR_ARBITER -- requirements
Module: crc_dir_arbiter

Interface
REQ-001 Parameter AW, default 4, is the directory address width (task key).
REQ-002 Parameter DW, default 16, is the directory data width.
REQ-003 Parameter RD_LAT, default 2, is the number of cycles from mem_en to valid mem_rdata on a read.
REQ-004 Parameter STARVE_MAX, default 4, is the lost-grant count at which a core gains top priority.
REQ-005 Port clk, input, 1, is the single clock; all logic SHALL be on posedge clk.
REQ-006 Port rst, input, 1, is the reset; it SHALL be asynchronous and active-high.
REQ-007 Port req, input, 3, carries level requests; bit0 is the comparator, bit1 is core1, bit2 is core2.
REQ-008 Port we, input, 3, is the per-requester write flag, where 1 means write and 0 means read.
REQ-009 Port adr_i, input, 3*AW, carries the per-requester address; slice k is [k*AW +: AW].
REQ-010 Port wdata_i, input, 3*DW, carries the per-requester write data; slice k is [k*DW +: DW].
REQ-011 Port ack, output, 3, is a one-cycle completion pulse per requester.
REQ-012 Port rdata_o, output, DW, is the read data, valid while ack is high for a read.
REQ-013 Port busy, output, 1, is high whenever the state is not IDLE.
REQ-014 Port grant_id, output, 2, is the latched winner (0..2), or 3 in IDLE.
REQ-015 Ports mem_en/mem_we (1), mem_adr (AW), mem_wdata (DW) are outputs and mem_rdata (DW) is an input; together they form the directory RAM port.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, and DONE.
REQ-017 In IDLE, if any req bit is set, the block SHALL select a winner, latch id/we/adr/wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Winner priority SHALL be: starved core first; then the comparator; then round-robin between the cores, preferring the core not granted last.
REQ-019 A core SHALL be starved when its counter equals STARVE_MAX; if both cores are starved, round-robin SHALL decide.
REQ-020 Each core counter (3 bits, saturating) SHALL:
- increment on each grant to another requester while that core's req is high;
- clear when that core is granted.
REQ-021 The round-robin pointer SHALL update only on core grants and SHALL reset to "core2 last".
REQ-022 ISSUE SHALL last one cycle with mem_en=1, mem_we=latched we, and mem_adr/mem_wdata driven from the latched values.
REQ-023 From ISSUE, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-024 WAIT SHALL last exactly RD_LAT cycles with mem_en=0; on its last cycle rdata_o SHALL capture mem_rdata, then the FSM goes to DONE.
REQ-025 DONE SHALL last one cycle with ack[id]=1 and all other ack bits 0, then the FSM returns to IDLE.
REQ-026 Latency from the req sample in IDLE to ack SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-027 Requesters SHALL hold req, we, adr_i, and wdata_i stable until ack and deassert req on the ack edge.
REQ-028 Req is sampled only in IDLE; a req still high in IDLE after DONE SHALL be treated as a new transaction.
REQ-029 A req dropped mid-transaction SHALL NOT abort it; the FSM completes and still pulses ack.
REQ-030 rdata_o SHALL hold its value until the next read capture.
REQ-031 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_adr and mem_wdata SHALL hold their last values.
REQ-032 At most one ack bit SHALL be high in any cycle, and at most one transaction SHALL be outstanding.

Reset
REQ-033 On rst, the block SHALL immediately set:
- state = IDLE;
- ack, mem_en, mem_we = 0;
- mem_adr, mem_wdata, rdata_o = 0;
- busy = 0, grant_id = 3;
- starve counters = 0.
REQ-034 Reset during ISSUE or WAIT SHALL abandon the transaction with no ack, and no ack SHALL follow reset release.

Verification
REQ-035 Single write: req=3'b010, we=3'b010, adr1=5, wdata1=16'hBEEF -> mem_en/mem_we=1, mem_adr=5, mem_wdata=BEEF one cycle after sample; ack=3'b010 two cycles after sample.
REQ-036 Read latency: req=3'b001, we=0, adr0=9, mem_rdata=16'h1234 two cycles after mem_en -> ack=3'b001 with rdata_o=1234, four cycles after sample.
REQ-037 Simultaneous requests: req=3'b111, each requester dropping on its ack and re-raising the next cycle -> grant order 0,1,0,2,0,1,... with no requester waiting more than STARVE_MAX grants.
REQ-038 Starvation: the comparator holds req continuously and core2 holds req -> core2's counter reaches 4, and core2 is granted at the next IDLE ahead of the comparator.
REQ-039 Reset mid-read: rst asserted in WAIT -> busy=0, grant_id=3, mem_en=0 immediately; no ack observed after release.
REQ-040 Protocol robustness: req dropped during WAIT -> ack still pulsed once and the FSM returns to IDLE.

Source files
------------

// File: rtl/crc_dir_arbiter.sv
// crc_dir_arbiter: serialises directory RAM accesses from the comparator and two cores,
// with starvation-aware priority and a fixed-latency read path.
module crc_dir_arbiter #(
  parameter int AW         = 4,
  parameter int DW         = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] adr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata_o,
  output logic            busy,
  output logic [1:0]      grant_id,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_adr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  state_e        state_q;
  logic [2:0]    cnt1_q, cnt2_q, cnt1_d, cnt2_d;
  logic          rr2_q;
  logic          we_q;
  logic [CW-1:0] wcnt_q;
  logic          st1, st2;
  logic [1:0]    pref, win;
  logic          win_we;
  logic [AW-1:0] win_adr;
  logic [DW-1:0] win_wdata;
  // rr2_q set means core2 was the last core granted, so core1 is preferred next
  always_comb begin
    st1       = req[1] && cnt1_q == 3'(STARVE_MAX);
    st2       = req[2] && cnt2_q == 3'(STARVE_MAX);
    pref      = rr2_q ? 2'd1 : 2'd2;
    win       = (st1 && st2) ? pref :
                st1 ? 2'd1 :
                st2 ? 2'd2 :
                req[0] ? 2'd0 :
                (req[1] && req[2]) ? pref :
                req[1] ? 2'd1 : 2'd2;
    win_we    = win == 2'd2 ? we[2] : win == 2'd1 ? we[1] : we[0];
    win_adr   = win == 2'd2 ? adr_i[2*AW +: AW] : win == 2'd1 ? adr_i[AW +: AW] : adr_i[0 +: AW];
    win_wdata = win == 2'd2 ? wdata_i[2*DW +: DW] : win == 2'd1 ? wdata_i[DW +: DW] : wdata_i[0 +: DW];
    cnt1_d    = win == 2'd1 ? 3'd0 : (req[1] && cnt1_q != 3'd7) ? cnt1_q + 3'd1 : cnt1_q;
    cnt2_d    = win == 2'd2 ? 3'd0 : (req[2] && cnt2_q != 3'd7) ? cnt2_q + 3'd1 : cnt2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack       <= '0;
      rdata_o   <= '0;
      busy      <= 1'b0;
      grant_id  <= 2'd3;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      rr2_q     <= 1'b1;
      we_q      <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          state_q   <= ISSUE;
          busy      <= 1'b1;
          grant_id  <= win;
          we_q      <= win_we;
          mem_en    <= 1'b1;
          mem_we    <= win_we;
          mem_adr   <= win_adr;
          mem_wdata <= win_wdata;
          cnt1_q    <= cnt1_d;
          cnt2_q    <= cnt2_d;
          if (win != 2'd0) rr2_q <= win == 2'd2;
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          wcnt_q  <= '0;
          state_q <= we_q ? DONE : WAIT;
          if (we_q) ack <= 3'b001 << grant_id;
        end
        WAIT: if (wcnt_q == CW'(RD_LAT - 1)) begin
          rdata_o <= mem_rdata;
          ack     <= 3'b001 << grant_id;
          state_q <= DONE;
        end else begin
          wcnt_q <= wcnt_q + CW'(1);
        end
        DONE: begin
          ack      <= '0;
          busy     <= 1'b0;
          grant_id <= 2'd3;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_dir_arbiter.sv
// tb_crc_dir_arbiter: transaction-level reference model of the arbiter compared every cycle,
// plus directed literal checks for latency, grant order, starvation and reset.
module tb_crc_dir_arbiter;
  localparam int AW = 4, DW = 16, RD_LAT = 2, SM = 4;
  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req, we;
  logic [3*AW-1:0] adr_i;
  logic [3*DW-1:0] wdata_i;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata_o;
  logic            busy;
  logic [1:0]      grant_id;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_adr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  crc_dir_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .adr_i(adr_i), .wdata_i(wdata_i),
    .ack(ack), .rdata_o(rdata_o), .busy(busy), .grant_id(grant_id),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // directory RAM: read data valid only in the RD_LAT-th cycle after mem_en, junk otherwise
  logic [DW-1:0] ram [16] = '{default: '0};
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_adr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_adr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  logic [DW-1:0] m_mem [16] = '{default: '0};
  bit            m_busy, m_we;
  int            m_age, m_id, m_last;
  int            m_cnt [3];
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wd, m_rd;
  logic [2:0]    e_ack;
  logic [DW-1:0] e_rdata, e_mwd;
  logic          e_busy, e_en, e_mwe;
  logic [1:0]    e_gid;
  logic [AW-1:0] e_madr;
  int            glog [$];
  int            n_cmp = 0, n_bad = 0;
  bit            auto_on;
  int            prob [3], keep [3], cool [3];
  int            hold, drop, g0, seen;
  int            e037 [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
  int            e038 [6] = '{0, 0, 0, 0, 2, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_busy = 0; m_cnt = '{0, 0, 0}; m_last = 2;
    e_ack = 0; e_rdata = 0; e_busy = 0; e_gid = 2'd3; e_en = 0; e_mwe = 0; e_madr = 0; e_mwd = 0;
  endtask

  // one clock of the transaction model: grant by rules, then count cycles to completion
  task automatic mdl_tick();
    int w, done_at, rrp;
    bit s1, s2;
    if (rst) begin
      mdl_reset();
      return;
    end
    if (m_busy) begin
      m_age++; e_en = 0; e_mwe = 0;
      done_at = m_we ? 2 : 2 + RD_LAT;
      if (m_age == done_at) begin
        e_ack = 3'(1 << m_id);
        if (!m_we) e_rdata = m_rd;
      end else if (m_age > done_at) begin
        e_ack = 0; e_busy = 0; e_gid = 2'd3; m_busy = 0;
      end
    end else if (req != 0) begin
      s1 = req[1] && m_cnt[1] == SM;
      s2 = req[2] && m_cnt[2] == SM;
      rrp = m_last == 2 ? 1 : 2;
      if (s1 && s2) w = rrp;
      else if (s1) w = 1;
      else if (s2) w = 2;
      else if (req[0]) w = 0;
      else if (req[1] && req[2]) w = rrp;
      else w = req[1] ? 1 : 2;
      for (int c = 1; c < 3; c++)
        if (c == w) m_cnt[c] = 0;
        else if (req[c] && m_cnt[c] < 7) m_cnt[c]++;
      if (w != 0) m_last = w;
      m_busy = 1; m_age = 1; m_id = w; m_we = we[w];
      m_adr = adr_i[w*AW +: AW]; m_wd = wdata_i[w*DW +: DW];
      if (m_we) m_mem[m_adr] = m_wd;
      m_rd = m_mem[m_adr];
      e_en = 1; e_mwe = m_we; e_madr = m_adr; e_mwd = m_wd; e_busy = 1; e_gid = 2'(w); e_ack = 0;
      glog.push_back(w);
    end
  endtask

  task automatic compare();
    chk("ack", ack, e_ack);
    chk("rdata_o", rdata_o, e_rdata);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, e_gid);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_mwe);
    chk("mem_adr", mem_adr, e_madr);
    chk("mem_wdata", mem_wdata, e_mwd);
  endtask

  task automatic drive();
    if (!auto_on) return;
    for (int k = 0; k < 3; k++) begin
      if (ack[k] && keep[k] == 0) begin
        req[k] = 0; cool[k] = hold;
      end else if (!req[k]) begin
        if (cool[k] > 0) cool[k]--;
        else if (int'($urandom_range(99)) < prob[k]) begin
          req[k] = 1; we[k] = 1'($urandom_range(1));
          adr_i[k*AW +: AW] = AW'($urandom); wdata_i[k*DW +: DW] = DW'($urandom);
        end
      end else if (keep[k] == 0 && int'($urandom_range(99)) < drop) req[k] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    mdl_tick();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic do_reset();
    rst = 1; mdl_reset();
    step();
    rst = 0; cool = '{0, 0, 0};
  endtask

  task automatic drain();
    auto_on = 0; req = 0;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("drain_idle", busy, 0);
    step();
  endtask

  initial begin
    rst = 1; req = 0; we = 0; adr_i = 0; wdata_i = 0;
    auto_on = 0; hold = 0; drop = 0;
    prob = '{0, 0, 0}; keep = '{0, 0, 0}; cool = '{0, 0, 0};
    mdl_reset();
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 3);
    chk("rst_ack", ack, 0);
    chk("rst_mem_en", mem_en, 0);
    rst = 0;
    step();
    // single write from core1
    req = 3'b010; we = 3'b010; adr_i[AW +: AW] = 4'd5; wdata_i[DW +: DW] = 16'hBEEF;
    step();
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_adr", mem_adr, 5);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr_ack_early", ack, 0);
    step();
    chk("wr_ack", ack, 3'b010);
    req = 0;
    step();
    chk("wr_idle", busy, 0);
    // comparator writes 0x1234 to address 9, then reads it back
    req = 3'b001; we = 3'b001; adr_i[0 +: AW] = 4'd9; wdata_i[0 +: DW] = 16'h1234;
    step(); step();
    chk("wr9_ack", ack, 3'b001);
    req = 0;
    step();
    req = 3'b001; we = 3'b000;
    step();
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_adr", mem_adr, 9);
    step(); step();
    chk("rd_ack_early", ack, 0);
    step();
    chk("rd_ack", ack, 3'b001);
    chk("rd_data", rdata_o, 16'h1234);
    chk("mdl_rd_data", e_rdata, 16'h1234);
    req = 0;
    step(); step();
    // all three requesting, each dropping on ack and re-raising a cycle later
    do_reset();
    prob = '{100, 100, 100}; keep = '{0, 0, 0}; hold = 1; drop = 0; g0 = glog.size();
    auto_on = 1; drive();
    for (int i = 0; i < 300 && glog.size() < g0 + 8; i++) step();
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_order%0d", i), (g0 + i < glog.size()) ? glog[g0+i] : -1, e037[i]);
    drain();
    // comparator and core2 hold req continuously: core2 wins after four lost grants
    do_reset();
    prob = '{100, 0, 100}; keep = '{1, 0, 1}; hold = 0; g0 = glog.size();
    auto_on = 1; drive();
    for (int i = 0; i < 300 && glog.size() < g0 + 6; i++) step();
    for (int i = 0; i < 6; i++)
      chk($sformatf("starve_order%0d", i), (g0 + i < glog.size()) ? glog[g0+i] : -1, e038[i]);
    drain();
    // random traffic
    do_reset();
    keep = '{0, 0, 0}; drop = 3;
    for (int b = 0; b < 3; b++) begin
      prob = '{int'($urandom_range(20, 80)), int'($urandom_range(20, 80)), int'($urandom_range(20, 80))};
      hold = int'($urandom_range(2));
      auto_on = 1;
      repeat (1000) step();
    end
    drain();
    // reset asserted while waiting on a read
    req = 3'b001; we = 3'b000; adr_i[0 +: AW] = 4'd3;
    step(); step();
    chk("rm_busy_pre", busy, 1);
    #2 rst = 1; mdl_reset();
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_gid", grant_id, 3);
    chk("rm_mem_en", mem_en, 0);
    chk("rm_ack", ack, 0);
    req = 0;
    step();
    rst = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack != 0) seen++;
    end
    chk("rm_no_ack", seen, 0);
    // req dropped during WAIT still completes with a single ack
    req = 3'b010; we = 3'b000; adr_i[AW +: AW] = 4'd7;
    step(); step();
    req = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack[1]) seen++;
    end
    chk("drop_acks", seen, 1);
    chk("drop_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
